// File: rtl/alu_cmd_driver_if.sv
// Request, ALU-side and response signals between the command driver and its neighbours.
// The slave modport is the driver; the master modport is the requester/ALU/consumer side.
interface alu_cmd_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_opcode;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic       alu_en;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_cout;
  logic       rsp_err;
  logic [7:0] op_count;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_out, alu_cout, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, alu_en,
           rsp_valid, rsp_out, rsp_cout, rsp_err, op_count
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_out, alu_cout, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, alu_en,
           rsp_valid, rsp_out, rsp_cout, rsp_err, op_count
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Self-timed command engine in front of the 8-bit ALU: accepts a request, drives
// operands through a setup/enable sequence, captures the result and returns it.
module alu_cmd_driver #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned EN_CYCLES    = 2,
  parameter logic [15:0] OPCODE_MASK  = 16'hC0D0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ENABLE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       alu_a_q,     alu_a_d;
  logic [7:0]       alu_b_q,     alu_b_d;
  logic [3:0]       alu_op_q,    alu_op_d;
  logic             alu_en_q,    alu_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_out_q,   rsp_out_d;
  logic             rsp_cout_q,  rsp_cout_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [7:0]       op_count_q,  op_count_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_en_d    = alu_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (OPCODE_MASK[bus.req_opcode]) begin
            alu_a_d  = bus.req_a;
            alu_b_d  = bus.req_b;
            alu_op_d = bus.req_opcode;
            cnt_d    = '0;
            state_d  = ST_SETUP;
          end else begin
            // Illegal opcode: the ALU is never touched, an error response is returned
            rsp_valid_d = 1'b1;
            rsp_out_d   = 8'd0;
            rsp_cout_d  = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          alu_en_d = 1'b1;
          state_d  = ST_ENABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d       = '0;
          alu_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_out_d   = bus.alu_out;
          rsp_cout_d  = bus.alu_cout;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_op_q    <= 4'd0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 8'd0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  // Ready is a pure state decode, held low while reset is applied
  assign bus.req_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator-side companion to the 8-bit ALU (a, b, opcode, en in; out, cout back).
- Accepts operation requests over a valid/ready handshake and sequences the ALU's setup/enable protocol: operands and opcode stable, then an en pulse.
- Captures out/cout and returns them on a valid/ready response channel.
- Replaces hand-timed stimulus with a reusable, self-timed command engine in front of the ALU.

Parameters:
- SETUP_CYCLES, 1, cycles operands/opcode are driven with alu_en low before enable (legal range 1..15).
- EN_CYCLES, 2, cycles alu_en is held high (legal range 1..15).
- OPCODE_MASK, 16'hC0D0, bit n set means opcode n is legal. Default legal set is 1111 add, 1110 sub, 0111 and, 0110 or, 0100 not.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_opcode  input  4  ALU opcode.
- req_a  input  8  operand a.
- req_b  input  8  operand b.
- alu_a  output  8  to ALU a.
- alu_b  output  8  to ALU b.
- alu_opcode  output  4  to ALU opcode.
- alu_en  output  1  to ALU en.
- alu_out  input  8  from ALU out.
- alu_cout  input  1  from ALU cout.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_out  output  8  captured result.
- rsp_cout  output  1  captured carry.
- rsp_err  output  1  request had an illegal opcode.
- op_count  output  8  completed responses, wraps 255->0.

Behaviour:
- Reset (rst_n low at a rising edge) clears everything to 0: state to IDLE, alu_a, alu_b, alu_opcode, alu_en, rsp_valid, rsp_out, rsp_cout, rsp_err, op_count, internal counter. req_ready is 1 in IDLE and 0 while reset is asserted.
- FSM states: IDLE, SETUP, ENABLE, RESP. All outputs are registered; req_ready is decoded from state.
- IDLE: req_ready=1.
  - On req_valid&req_ready with a legal opcode: latch opcode, a and b onto alu_* and go to SETUP.
  - With an illegal opcode (mask bit 0): alu_* are unchanged and alu_en never rises. Go directly to RESP with rsp_out=0, rsp_cout=0, rsp_err=1. rsp_valid is high the cycle after acceptance.
- SETUP: alu_en=0, alu_* held. After SETUP_CYCLES cycles go to ENABLE.
- ENABLE: alu_en=1 for exactly EN_CYCLES cycles.
  - At the edge ending the last ENABLE cycle, register alu_out->rsp_out, alu_cout->rsp_cout, rsp_err=0, rsp_valid=1.
  - That same edge drops alu_en to 0 and enters RESP.
- Latency: with acceptance at edge E, alu_en rises at E+SETUP_CYCLES and rsp_valid rises at E+SETUP_CYCLES+EN_CYCLES. Defaults give rsp_valid at E+3.
- RESP: rsp_* held stable while rsp_valid&!rsp_ready, for any number of cycles.
  - On rsp_valid&rsp_ready: clear rsp_valid, increment op_count (mod 256), return to IDLE.
  - Error responses also increment op_count.
- alu_a, alu_b and alu_opcode keep their last values after the operation; they change only on the next accepted legal request.
- req_ready=0 in SETUP, ENABLE and RESP. Requests during those states are not accepted and the requester must hold them. There is no back-to-back overlap; minimum period per legal op is SETUP_CYCLES+EN_CYCLES+2 cycles.
- req_* inputs are sampled only at acceptance; later changes have no effect on the in-flight op.
- Reset mid-operation, in any state: the in-flight op is discarded. alu_en is 0 after the reset edge, no response is produced, op_count=0.
- op_count wraps from 255 to 0 with no flag.

Test Plan:
- Reset, then add (1111), a=FF, b=FF, real ALU attached -> alu_en high exactly 2 cycles starting E+1, rsp_valid at E+3, rsp_out=FE, rsp_cout=1, rsp_err=0, op_count=1.
- OR (0110) CC|33 -> rsp_out=FF. NOT (0100) a=AA -> rsp_out=55. AND (0111) CC&33 -> rsp_out=00. SUB (1110) 00-01 -> rsp_out=FF and rsp_cout equals alu_cout sampled on the last enable cycle. Each op must see alu_a, alu_b and alu_opcode stable from SETUP through ENABLE.
- Illegal opcode 0000 -> alu_en never rises, alu_* unchanged, rsp_valid at E+1 with rsp_err=1 and rsp_out=00.
- Backpressure: hold rsp_ready low 5 cycles with req_valid high and a second request pending -> rsp_* stable, req_ready=0 throughout. The second request is accepted the cycle after the response handshake.
- Assert rst_n low during ENABLE -> alu_en=0 and rsp_valid=0 after the reset edge, op_count=0, and the next request completes normally.
- Run 256 legal ops with rsp_ready tied high -> op_count returns to 0. Also set SETUP_CYCLES=3, EN_CYCLES=1 -> rsp_valid at E+4.
